// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP CPU port: register indices,
// display modes, status bit positions and the control-code encoding.
package vdp_pkg;

  localparam int NUM_REGS = 11;

  localparam logic [3:0] R_MODE0   = 4'd0;
  localparam logic [3:0] R_MODE1   = 4'd1;
  localparam logic [3:0] R_NAME    = 4'd2;
  localparam logic [3:0] R_COLOR   = 4'd3;
  localparam logic [3:0] R_FONT    = 4'd4;
  localparam logic [3:0] R_SATTR   = 4'd5;
  localparam logic [3:0] R_SPAT    = 4'd6;
  localparam logic [3:0] R_COLORS  = 4'd7;
  localparam logic [3:0] R_XSCROLL = 4'd8;
  localparam logic [3:0] R_YSCROLL = 4'd9;
  localparam logic [3:0] R_VCOUNT  = 4'd10;

  localparam logic [2:0] MODE_TEXT = 3'd0;
  localparam logic [2:0] MODE_G1   = 3'd1;
  localparam logic [2:0] MODE_G2   = 3'd2;
  localparam logic [2:0] MODE_MC   = 3'd3;
  localparam logic [2:0] MODE_M4   = 3'd4;

  localparam int ST_INT = 7;
  localparam int ST_S5  = 6;
  localparam int ST_COL = 5;

  typedef enum logic [1:0] {
    CC_READ  = 2'b00,
    CC_WRITE = 2'b01,
    CC_REG   = 2'b10,
    CC_CRAM  = 2'b11
  } ctrl_code_e;

  typedef enum logic {
    LATCH_FIRST  = 1'b0,
    LATCH_SECOND = 1'b1
  } latch_state_e;

endpackage

// File: rtl/vdp_regs.sv
// VDP register file R0-R10 and the combinational decode that feeds the
// video block its mode, table bases, colours and scroll values.
module vdp_regs
  import vdp_pkg::*;
(
  input  logic        clk,
  input  logic        n_reset,
  input  logic        reg_we,
  input  logic [3:0]  reg_idx,
  input  logic [7:0]  reg_data,
  output logic [2:0]  mode,
  output logic [13:0] name_table_addr,
  output logic [13:0] color_table_addr,
  output logic [13:0] font_addr,
  output logic [13:0] sprite_attr_addr,
  output logic [13:0] sprite_pattern_table_addr,
  output logic        video_on,
  output logic        sprite_large,
  output logic        sprite_enlarged,
  output logic        vert_retrace_int,
  output logic [3:0]  text_color,
  output logic [3:0]  back_color,
  output logic [7:0]  x_scroll,
  output logic [7:0]  y_scroll
);

  logic [7:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (reg_we && reg_idx <= R_VCOUNT) begin
      regs_q[reg_idx] <= reg_data;
    end
  end

  // Mode priority: M4 overrides everything, then text, multicolour, G2.
  always_comb begin
    mode = MODE_G1;
    if (regs_q[R_MODE0][2])      mode = MODE_M4;
    else if (regs_q[R_MODE1][4]) mode = MODE_TEXT;
    else if (regs_q[R_MODE1][3]) mode = MODE_MC;
    else if (regs_q[R_MODE0][1]) mode = MODE_G2;
  end

  assign video_on         = regs_q[R_MODE1][6];
  assign vert_retrace_int = regs_q[R_MODE1][5];
  assign sprite_large     = regs_q[R_MODE1][1];
  assign sprite_enlarged  = regs_q[R_MODE1][0];

  assign name_table_addr           = {regs_q[R_NAME][3:0], 10'b0};
  assign color_table_addr          = {regs_q[R_COLOR], 6'b0};
  assign font_addr                 = {regs_q[R_FONT][2:0], 11'b0};
  assign sprite_attr_addr          = {regs_q[R_SATTR][6:0], 7'b0};
  assign sprite_pattern_table_addr = {regs_q[R_SPAT][2:0], 11'b0};

  assign text_color = regs_q[R_COLORS][7:4];
  assign back_color = regs_q[R_COLORS][3:0];
  assign x_scroll   = regs_q[R_XSCROLL];
  assign y_scroll   = regs_q[R_YSCROLL];

  // R10 (line counter) and the high bits of the base registers are stored only.
  logic unused_bits;
  assign unused_bits = ^{regs_q[R_VCOUNT], regs_q[R_MODE0][7:3], regs_q[R_MODE0][0],
                         regs_q[R_MODE1][7], regs_q[R_MODE1][2], regs_q[R_NAME][7:4],
                         regs_q[R_FONT][7:3], regs_q[R_SATTR][7], regs_q[R_SPAT][7:3]};

endmodule

// File: rtl/vdp_port.sv
// CPU-side VDP port: control-byte latch, auto-incrementing VRAM address with
// read-ahead buffer, status flags and frame interrupt.
module vdp_port
  import vdp_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              port_sel,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_wr,
  output logic              vram_rd,
  output logic [7:0]        vram_dout,
  input  logic [7:0]        vram_din,
  input  logic              frame_int,
  input  logic              sprite_collision,
  input  logic              too_many_sprites,
  input  logic [4:0]        sprite5,
  output logic [2:0]        mode,
  output logic [13:0]       name_table_addr,
  output logic [13:0]       color_table_addr,
  output logic [13:0]       font_addr,
  output logic [13:0]       sprite_attr_addr,
  output logic [13:0]       sprite_pattern_table_addr,
  output logic              video_on,
  output logic              sprite_large,
  output logic              sprite_enlarged,
  output logic              vert_retrace_int,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color,
  output logic [7:0]        x_scroll,
  output logic [7:0]        y_scroll,
  output logic              n_int
);

  latch_state_e      latch_q, latch_d;
  logic [7:0]        latch_lo_q, latch_lo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        buf_q, buf_d;
  logic [7:0]        dout_q, dout_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wr_pend_q, wr_pend_d;
  logic              rd_pend_q, rd_pend_d;
  logic              fill_q, fill_d;
  logic              int_q, int_d;
  logic              col_q, col_d;
  logic              s5_q, s5_d;
  logic [4:0]        s5_num_q, s5_num_d;
  logic              reg_we;
  logic [7:0]        status_w;

  logic       ctrl_wr, ctrl_rd, data_wr, data_rd, second_byte;
  ctrl_code_e code;

  assign ctrl_wr     = cpu_wr & port_sel;
  assign ctrl_rd     = cpu_rd & port_sel;
  assign data_wr     = cpu_wr & ~port_sel;
  assign data_rd     = cpu_rd & ~port_sel;
  assign second_byte = ctrl_wr && (latch_q == LATCH_SECOND);
  assign code        = ctrl_code_e'(cpu_din[7:6]);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) latch_q <= LATCH_FIRST;
    else          latch_q <= latch_d;
  end

  // Any access other than a control write resynchronises the byte pair.
  always_comb begin
    latch_d = latch_q;
    if (ctrl_wr)
      latch_d = (latch_q == LATCH_FIRST) ? LATCH_SECOND : LATCH_FIRST;
    else if (data_wr || data_rd || ctrl_rd)
      latch_d = LATCH_FIRST;
  end

  always_comb begin
    status_w         = '0;
    status_w[ST_INT] = int_q;
    status_w[ST_S5]  = s5_q;
    status_w[ST_COL] = col_q;
    status_w[4:0]    = s5_num_q;
  end

  // VRAM accesses are issued the cycle after the strobe; the address advances
  // on that access cycle so vram_addr always shows the location being touched.
  always_comb begin
    latch_lo_d = latch_lo_q;
    addr_d     = addr_q;
    buf_d      = buf_q;
    dout_d     = dout_q;
    wdata_d    = wdata_q;
    wr_pend_d  = 1'b0;
    rd_pend_d  = 1'b0;
    fill_d     = rd_pend_q;
    reg_we     = 1'b0;

    if (wr_pend_q || rd_pend_q) addr_d = addr_q + ADDR_W'(1);
    if (fill_q) buf_d = vram_din;

    if (ctrl_wr && latch_q == LATCH_FIRST) latch_lo_d = cpu_din;
    if (second_byte) begin
      case (code)
        CC_REG:  reg_we = 1'b1;
        CC_READ: begin
          addr_d    = ADDR_W'({cpu_din[5:0], latch_lo_q});
          rd_pend_d = 1'b1;
        end
        default: addr_d = ADDR_W'({cpu_din[5:0], latch_lo_q});
      endcase
    end

    if (data_wr) begin
      wdata_d   = cpu_din;
      buf_d     = cpu_din;
      wr_pend_d = 1'b1;
    end
    if (data_rd) begin
      dout_d    = buf_q;
      rd_pend_d = 1'b1;
    end
    if (ctrl_rd) dout_d = status_w;
  end

  // Flag sets take priority over the clear from a status read.
  always_comb begin
    int_d    = frame_int | (int_q & ~ctrl_rd);
    col_d    = sprite_collision | (col_q & ~ctrl_rd);
    s5_d     = s5_q & ~ctrl_rd;
    s5_num_d = s5_num_q;
    if (too_many_sprites && !s5_q) begin
      s5_d     = 1'b1;
      s5_num_d = sprite5;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      latch_lo_q <= '0;
      addr_q     <= '0;
      buf_q      <= '0;
      dout_q     <= '0;
      wdata_q    <= '0;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      fill_q     <= 1'b0;
      int_q      <= 1'b0;
      col_q      <= 1'b0;
      s5_q       <= 1'b0;
      s5_num_q   <= '0;
    end else begin
      latch_lo_q <= latch_lo_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      dout_q     <= dout_d;
      wdata_q    <= wdata_d;
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      fill_q     <= fill_d;
      int_q      <= int_d;
      col_q      <= col_d;
      s5_q       <= s5_d;
      s5_num_q   <= s5_num_d;
    end
  end

  assign cpu_dout  = dout_q;
  assign vram_addr = addr_q;
  assign vram_wr   = wr_pend_q;
  assign vram_rd   = rd_pend_q;
  assign vram_dout = wdata_q;
  assign n_int     = ~(int_q & vert_retrace_int);

  vdp_regs u_regs (
    .clk                       (clk),
    .n_reset                   (n_reset),
    .reg_we                    (reg_we),
    .reg_idx                   (cpu_din[3:0]),
    .reg_data                  (latch_lo_q),
    .mode                      (mode),
    .name_table_addr           (name_table_addr),
    .color_table_addr          (color_table_addr),
    .font_addr                 (font_addr),
    .sprite_attr_addr          (sprite_attr_addr),
    .sprite_pattern_table_addr (sprite_pattern_table_addr),
    .video_on                  (video_on),
    .sprite_large              (sprite_large),
    .sprite_enlarged           (sprite_enlarged),
    .vert_retrace_int          (vert_retrace_int),
    .text_color                (text_color),
    .back_color                (back_color),
    .x_scroll                  (x_scroll),
    .y_scroll                  (y_scroll)
  );

endmodule

// File: tb/tb_vdp_port.sv
// Directed bench for vdp_port: a behavioural VRAM model answers port A and
// every expected value is hand-computed from the port's documented behaviour.
module tb_vdp_port;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        port_sel = 1'b0;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic [13:0] vram_addr;
  logic        vram_wr, vram_rd;
  logic [7:0]  vram_dout;
  logic [7:0]  vram_din = 8'h00;
  logic        frame_int = 1'b0;
  logic        sprite_collision = 1'b0;
  logic        too_many_sprites = 1'b0;
  logic [4:0]  sprite5 = 5'd0;
  logic [2:0]  mode;
  logic [13:0] name_table_addr, color_table_addr, font_addr;
  logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
  logic        video_on, sprite_large, sprite_enlarged, vert_retrace_int;
  logic [3:0]  text_color, back_color;
  logic [7:0]  x_scroll, y_scroll;
  logic        n_int;

  logic [7:0]  vram [0:16383];
  int          checkCount = 0;
  int          passCount = 0;
  logic        lastWr, lastRd, wrAfter;
  logic [13:0] lastAddr;

  vdp_port #(.ADDR_W(14)) dut (
    .clk                       (clk),
    .n_reset                   (n_reset),
    .port_sel                  (port_sel),
    .cpu_wr                    (cpu_wr),
    .cpu_rd                    (cpu_rd),
    .cpu_din                   (cpu_din),
    .cpu_dout                  (cpu_dout),
    .vram_addr                 (vram_addr),
    .vram_wr                   (vram_wr),
    .vram_rd                   (vram_rd),
    .vram_dout                 (vram_dout),
    .vram_din                  (vram_din),
    .frame_int                 (frame_int),
    .sprite_collision          (sprite_collision),
    .too_many_sprites          (too_many_sprites),
    .sprite5                   (sprite5),
    .mode                      (mode),
    .name_table_addr           (name_table_addr),
    .color_table_addr          (color_table_addr),
    .font_addr                 (font_addr),
    .sprite_attr_addr          (sprite_attr_addr),
    .sprite_pattern_table_addr (sprite_pattern_table_addr),
    .video_on                  (video_on),
    .sprite_large              (sprite_large),
    .sprite_enlarged           (sprite_enlarged),
    .vert_retrace_int          (vert_retrace_int),
    .text_color                (text_color),
    .back_color                (back_color),
    .x_scroll                  (x_scroll),
    .y_scroll                  (y_scroll),
    .n_int                     (n_int)
  );

  always #5 clk = ~clk;

  // VRAM port A model: synchronous write, read data one cycle after vram_rd.
  always @(posedge clk) begin
    if (vram_wr) vram[vram_addr] <= vram_dout;
    if (vram_rd) vram_din <= vram[vram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // One CPU strobe followed by idle cycles; snapshots the VRAM strobes the
  // cycle after the strobe and the cycle after that.
  task automatic applyStimulus(input logic sel, input logic wr, input logic [7:0] data);
    @(negedge clk);
    port_sel = sel;
    cpu_wr   = wr;
    cpu_rd   = ~wr;
    cpu_din  = data;
    @(negedge clk);
    cpu_wr   = 1'b0;
    cpu_rd   = 1'b0;
    lastWr   = vram_wr;
    lastRd   = vram_rd;
    lastAddr = vram_addr;
    @(negedge clk);
    wrAfter  = vram_wr | vram_rd;
    @(negedge clk);
  endtask

  task automatic regWrite(input logic [3:0] idx, input logic [7:0] val);
    applyStimulus(1'b1, 1'b1, val);
    applyStimulus(1'b1, 1'b1, {4'h8, idx});
  endtask

  task automatic pulseReset();
    @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
    vram[14'h1234] = 8'h5A;
    vram[14'h1235] = 8'hC3;

    #2;
    checkOutput("reset_cpu_dout", {24'b0, cpu_dout}, 32'h00);
    checkOutput("reset_n_int", {31'b0, n_int}, 32'h1);
    checkOutput("reset_mode", {29'b0, mode}, 32'h1);
    checkOutput("reset_vram_strobes", {30'b0, vram_wr, vram_rd}, 32'h0);
    checkOutput("reset_name_table", {18'b0, name_table_addr}, 32'h0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;

    regWrite(4'd1, 8'h02);
    checkOutput("r1_sprite_large", {31'b0, sprite_large}, 32'h1);
    checkOutput("r1_mode_g1", {29'b0, mode}, 32'h1);
    regWrite(4'd1, 8'h60);
    checkOutput("r1_video_on", {31'b0, video_on}, 32'h1);
    checkOutput("r1_vert_retrace", {31'b0, vert_retrace_int}, 32'h1);
    checkOutput("r1_sprite_large_off", {31'b0, sprite_large}, 32'h0);
    checkOutput("r1_mode_still_g1", {29'b0, mode}, 32'h1);

    regWrite(4'd0, 8'h02);
    checkOutput("mode_g2", {29'b0, mode}, 32'h2);
    regWrite(4'd1, 8'h68);
    checkOutput("mode_mc", {29'b0, mode}, 32'h3);
    regWrite(4'd1, 8'h70);
    checkOutput("mode_text", {29'b0, mode}, 32'h0);
    regWrite(4'd0, 8'h04);
    checkOutput("mode_m4", {29'b0, mode}, 32'h4);
    regWrite(4'd0, 8'h00);
    regWrite(4'd1, 8'h61);
    checkOutput("mode_back_g1", {29'b0, mode}, 32'h1);
    checkOutput("sprite_enlarged", {31'b0, sprite_enlarged}, 32'h1);
    regWrite(4'd1, 8'h60);

    regWrite(4'd2, 8'hFE);
    checkOutput("name_table_addr", {18'b0, name_table_addr}, 32'h3800);
    regWrite(4'd3, 8'hFF);
    checkOutput("color_table_addr", {18'b0, color_table_addr}, 32'h3FC0);
    regWrite(4'd4, 8'hFD);
    checkOutput("font_addr", {18'b0, font_addr}, 32'h2800);
    regWrite(4'd5, 8'hFF);
    checkOutput("sprite_attr_addr", {18'b0, sprite_attr_addr}, 32'h3F80);
    regWrite(4'd6, 8'h03);
    checkOutput("sprite_pattern_addr", {18'b0, sprite_pattern_table_addr}, 32'h1800);
    regWrite(4'd7, 8'hF1);
    checkOutput("colors", {24'b0, text_color, back_color}, 32'hF1);
    regWrite(4'd8, 8'h55);
    regWrite(4'd9, 8'hA5);
    checkOutput("scroll", {16'b0, x_scroll, y_scroll}, 32'h55A5);
    regWrite(4'd3, 8'h00);
    regWrite(4'd11, 8'h77);
    checkOutput("reg11_ignored_color", {18'b0, color_table_addr}, 32'h0);
    checkOutput("reg11_ignored_xs", {24'b0, x_scroll}, 32'h55);

    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h40);
    checkOutput("setwr_no_prefetch", {31'b0, lastRd}, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'hAA);
    checkOutput("wr0_strobe", {17'b0, lastWr, lastAddr}, {17'b0, 1'b1, 14'h0000});
    checkOutput("wr0_single_cycle", {31'b0, wrAfter}, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'hBB);
    checkOutput("vram0", {24'b0, vram[14'h0000]}, 32'hAA);
    checkOutput("vram1", {24'b0, vram[14'h0001]}, 32'hBB);
    checkOutput("addr_after_writes", {18'b0, vram_addr}, 32'h0002);

    applyStimulus(1'b1, 1'b1, 8'h34);
    applyStimulus(1'b1, 1'b1, 8'h12);
    checkOutput("prefetch_strobe", {17'b0, lastRd, lastAddr}, {17'b0, 1'b1, 14'h1234});
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("read_1234", {24'b0, cpu_dout}, 32'h5A);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("read_1235", {24'b0, cpu_dout}, 32'hC3);

    applyStimulus(1'b1, 1'b1, 8'hFF);
    applyStimulus(1'b1, 1'b1, 8'h7F);
    applyStimulus(1'b0, 1'b1, 8'h11);
    checkOutput("wr_3fff_addr", {18'b0, lastAddr}, 32'h3FFF);
    applyStimulus(1'b0, 1'b1, 8'h22);
    checkOutput("wrap_addr", {18'b0, lastAddr}, 32'h0000);
    checkOutput("vram_3fff", {24'b0, vram[14'h3FFF]}, 32'h11);
    checkOutput("vram_wrap", {24'b0, vram[14'h0000]}, 32'h22);

    @(negedge clk);
    frame_int = 1'b1;
    @(negedge clk);
    frame_int = 1'b0;
    checkOutput("n_int_asserted", {31'b0, n_int}, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("status_int", {24'b0, cpu_dout}, 32'h80);
    checkOutput("n_int_cleared", {31'b0, n_int}, 32'h1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("status_after_clear", {24'b0, cpu_dout}, 32'h00);

    @(negedge clk);
    too_many_sprites = 1'b1;
    sprite5 = 5'h13;
    @(negedge clk);
    sprite5 = 5'h07;
    @(negedge clk);
    too_many_sprites = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("status_s5", {24'b0, cpu_dout}, 32'h53);
    @(negedge clk);
    sprite_collision = 1'b1;
    @(negedge clk);
    sprite_collision = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("status_col", {24'b0, cpu_dout}, 32'h33);

    @(negedge clk);
    port_sel = 1'b1;
    cpu_rd = 1'b1;
    frame_int = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
    frame_int = 1'b0;
    checkOutput("simul_read_value", {24'b0, cpu_dout}, 32'h13);
    checkOutput("simul_int_kept", {31'b0, n_int}, 32'h0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("simul_followup", {24'b0, cpu_dout}, 32'h93);

    applyStimulus(1'b1, 1'b1, 8'h12);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h34);
    applyStimulus(1'b1, 1'b1, 8'h12);
    checkOutput("latch_reset_by_read", {17'b0, lastRd, lastAddr}, {17'b0, 1'b1, 14'h1234});
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("latch_reset_data", {24'b0, cpu_dout}, 32'h5A);

    applyStimulus(1'b1, 1'b1, 8'h34);
    @(negedge clk);
    port_sel = 1'b1;
    cpu_wr = 1'b1;
    cpu_din = 8'h12;
    @(negedge clk);
    cpu_wr = 1'b0;
    n_reset = 1'b0;
    #1;
    checkOutput("reset_aborts_rd", {31'b0, vram_rd}, 32'h0);
    @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_regs_cleared", {29'b0, video_on, n_int, vert_retrace_int}, 32'h2);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("reset_no_buffer_fill", {24'b0, cpu_dout}, 32'h00);

    applyStimulus(1'b1, 1'b1, 8'h56);
    pulseReset();
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h40);
    checkOutput("reset_latch_no_prefetch", {31'b0, lastRd}, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h99);
    checkOutput("reset_latch_addr", {18'b0, lastAddr}, 32'h0000);
    checkOutput("reset_latch_vram", {24'b0, vram[14'h0000]}, 32'h99);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
